// File: rtl/mont_pkg.sv
// Shared encodings and default sizes for the Montgomery exponentiation controller.
package mont_pkg;

    localparam int MONT_WIDTH     = 512;
    localparam int MONT_EXP_WIDTH = 512;
    localparam int MONT_CNT_W     = 10;

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        MRST,
        MGO,
        MWAIT,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        SQ,
        MUL,
        POST
    } op_t;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for an external Montgomery multiplier.
// Keeps the accumulator and latched operands; result = x^e mod m after a final Mont(A,1).
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int WIDTH     = MONT_WIDTH,
    parameter int EXP_WIDTH = MONT_EXP_WIDTH,
    parameter int CNT_W     = MONT_CNT_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x_mont,
    input  logic [WIDTH-1:0]     r_mod_m,
    input  logic [EXP_WIDTH-1:0] e,
    input  logic [CNT_W-1:0]     e_len,
    input  logic [WIDTH-1:0]     m,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 mont_resetn,
    output logic                 mont_start,
    output logic [WIDTH-1:0]     mont_a,
    output logic [WIDTH-1:0]     mont_b,
    output logic [WIDTH-1:0]     mont_m,
    input  logic [WIDTH+1:0]     mont_c,
    input  logic                 mont_done
);

    localparam logic [CNT_W-1:0] IDX_MAX = CNT_W'(EXP_WIDTH);

    state_t               state, state_nxt;
    op_t                  op;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     x_r;
    logic [WIDTH-1:0]     m_r;
    logic [EXP_WIDTH-1:0] e_r;
    logic [CNT_W-1:0]     idx;
    logic [EXP_WIDTH-1:0] e_sh;
    logic                 e_bit;
    logic                 op_active;
    logic                 unused_c_msb;

    // Shift rather than index so idx may be wider than the select needs.
    assign e_sh         = e_r >> idx;
    assign e_bit        = e_sh[0];
    assign mont_m       = m_r;
    assign unused_c_msb = ^mont_c[WIDTH+1:WIDTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        op_active   = 1'b0;
        mont_a      = '0;
        mont_b      = '0;
        mont_start  = 1'b0;
        // Multiplier is released everywhere except IDLE/MRST/FIN, so each
        // start follows exactly one low cycle.
        mont_resetn = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = DECIDE;
            DECIDE: begin
                mont_resetn = 1'b1;
                state_nxt   = MRST;
            end
            MRST: begin
                op_active = 1'b1;
                state_nxt = MGO;
            end
            MGO: begin
                op_active   = 1'b1;
                mont_resetn = 1'b1;
                mont_start  = 1'b1;
                state_nxt   = MWAIT;
            end
            MWAIT: begin
                op_active   = 1'b1;
                mont_resetn = 1'b1;
                if (mont_done) begin
                    if (op == SQ && e_bit) state_nxt = MRST;
                    else if (op == POST)   state_nxt = FIN;
                    else                   state_nxt = DECIDE;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (op_active) begin
            mont_a = acc;
            case (op)
                SQ:      mont_b = acc;
                MUL:     mont_b = x_r;
                POST:    mont_b = WIDTH'(1);
                default: mont_b = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc    <= '0;
            x_r    <= '0;
            m_r    <= '0;
            e_r    <= '0;
            idx    <= '0;
            op     <= SQ;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc  <= r_mod_m;
                    x_r  <= x_mont;
                    m_r  <= m;
                    e_r  <= e;
                    idx  <= (e_len > IDX_MAX) ? IDX_MAX : e_len;
                    done <= 1'b0;
                    busy <= 1'b1;
                end
                DECIDE: begin
                    if (idx == '0) begin
                        op <= POST;
                    end else begin
                        op  <= SQ;
                        idx <= idx - CNT_W'(1);
                    end
                end
                MWAIT: if (mont_done) begin
                    acc <= mont_c[WIDTH-1:0];
                    if (op == SQ && e_bit) op <= MUL;
                end
                FIN: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
